// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter. The controller (master) drives the
// control strobes; the counter (slave) returns its registered count and status.
interface down_counter_if #(
   parameter int COUNTER_WIDTH = 5
);
   // Control strobes are level-sampled on every rising clock edge that sees
   // clock_enable=1. There is no valid/ready pairing: the counter accepts a strobe
   // on the enabled edge that samples it. A strobe held for several enabled edges
   // is seen again on each of them, and an earlier command overrides a later one
   // in this order: load_enable, abort, start.
   logic                     clock_enable;
   logic                     load_enable;
   logic [COUNTER_WIDTH-1:0] load_value;
   logic                     start;
   logic                     abort;
   logic [COUNTER_WIDTH-1:0] iterator;
   logic                     busy;
   logic                     done;
   logic                     terminal;

   modport master (
      output clock_enable, load_enable, load_value, start, abort,
      input  iterator, busy, done, terminal
   );

   modport slave (
      input  clock_enable, load_enable, load_value, start, abort,
      output iterator, busy, done, terminal
   );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with an IDLE/RUN/DONE sequencer, optional auto-reload
// from the last loaded value, and clock-enable gating of all state.
module down_counter #(
   parameter int COUNTER_WIDTH = 5,
   parameter bit AUTO_RELOAD   = 1'b0
) (
   input  logic                 clock,
   input  logic                 reset,
   down_counter_if.slave        bus,
   output logic [1:0]           state_debug
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [COUNTER_WIDTH-1:0] ZERO = '0;
   localparam logic [COUNTER_WIDTH-1:0] ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] iterator_q;
   logic [COUNTER_WIDTH-1:0] reload_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         iterator_q <= ZERO;
         reload_q   <= ZERO;
      end else if (bus.clock_enable) begin
         if (bus.load_enable) begin
            iterator_q <= bus.load_value;
            reload_q   <= bus.load_value;
            state_q    <= IDLE;
         end else if (bus.abort && (state_q != IDLE)) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  // A zero count skips RUN and still produces its done pulse.
                  if (bus.start) begin
                     state_q <= (iterator_q != ZERO) ? RUN : DONE;
                  end
               end
               RUN: begin
                  if (iterator_q != ZERO) begin
                     iterator_q <= iterator_q - ONE;
                     if (iterator_q == ONE) begin
                        state_q <= DONE;
                     end
                  end else begin
                     state_q <= DONE;
                  end
               end
               DONE: begin
                  if (AUTO_RELOAD && (reload_q != ZERO)) begin
                     iterator_q <= reload_q;
                     state_q    <= RUN;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.iterator = iterator_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.terminal = (iterator_q == ZERO);
   assign state_debug  = state_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: a plain instance and an auto-reload instance, driven by a
// vector table plus directed multi-cycle sequences, checked through an expected queue.
module tb_down_counter;

   localparam int W = 5;

   logic       clock;
   logic       reset;
   logic [1:0] state_debug;
   logic [1:0] state_debug_ar;

   down_counter_if #(.COUNTER_WIDTH(W)) bus ();
   down_counter_if #(.COUNTER_WIDTH(W)) bus_ar ();

   down_counter #(.COUNTER_WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .state_debug (state_debug)
   );

   down_counter #(.COUNTER_WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut_ar (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus_ar),
      .state_debug (state_debug_ar)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // scoreboard: {iterator, busy, done, terminal}
   logic [W+2:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         ce;
      logic         ld;
      logic [W-1:0] lv;
      logic         st;
      logic         ab;
      logic [W-1:0] e_it;
      logic         e_busy;
      logic         e_done;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic ce, input logic ld, input logic [W-1:0] lv,
                               input logic st, input logic ab, input logic [W-1:0] e_it,
                               input logic e_busy, input logic e_done);
      vec_t v;
      v.ce = ce; v.ld = ld; v.lv = lv; v.st = st; v.ab = ab;
      v.e_it = e_it; v.e_busy = e_busy; v.e_done = e_done;
      return v;
   endfunction

   task automatic expect_out(input logic [W-1:0] e_it, input logic e_busy, input logic e_done);
      exp_q.push_back({e_it, e_busy, e_done, (e_it == '0)});
   endtask

   task automatic compare(input int sel, input string name);
      logic [W+2:0] act;
      logic [W+2:0] exp;
      if (sel == 0) act = {bus.iterator, bus.busy, bus.done, bus.terminal};
      else          act = {bus_ar.iterator, bus_ar.busy, bus_ar.done, bus_ar.terminal};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected entry queued, got it=%0d busy=%b done=%b term=%b",
                  name, act[W+2:3], act[2], act[1], act[0]);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: got it=%0d busy=%b done=%b term=%b, expected it=%0d busy=%b done=%b term=%b",
                     name, act[W+2:3], act[2], act[1], act[0],
                     exp[W+2:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   // driver: apply inputs for one edge, queue expectation, sample 1ns after the edge
   task automatic step(input int sel, input logic ce, input logic ld, input logic [W-1:0] lv,
                       input logic st, input logic ab, input logic [W-1:0] e_it,
                       input logic e_busy, input logic e_done, input string name);
      if (sel == 0) begin
         bus.clock_enable = ce; bus.load_enable = ld; bus.load_value = lv;
         bus.start = st; bus.abort = ab;
      end else begin
         bus_ar.clock_enable = ce; bus_ar.load_enable = ld; bus_ar.load_value = lv;
         bus_ar.start = st; bus_ar.abort = ab;
      end
      expect_out(e_it, e_busy, e_done);
      @(posedge clock);
      #1;
      compare(sel, name);
   endtask

   task automatic check_now(input int sel, input logic [W-1:0] e_it, input logic e_busy,
                            input logic e_done, input string name);
      expect_out(e_it, e_busy, e_done);
      compare(sel, name);
   endtask

   initial begin
      bus.clock_enable = 1'b1; bus.load_enable = 1'b0; bus.load_value = '0;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus_ar.clock_enable = 1'b1; bus_ar.load_enable = 1'b0; bus_ar.load_value = '0;
      bus_ar.start = 1'b0; bus_ar.abort = 1'b0;
      reset = 1'b0;

      vecs[0]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b1); // zero-length start
      vecs[1]  = mk(1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
      vecs[2]  = mk(1'b1, 1'b1, 5'd17, 1'b0, 1'b0, 5'd17, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd17, 1'b1, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd17, 1'b0, 1'b0); // abort at 17
      vecs[5]  = mk(1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd17, 1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 5'd3,  1'b1, 1'b0, 5'd17, 1'b0, 1'b0); // gated
      vecs[7]  = mk(1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 5'd17, 1'b0, 1'b0); // abort in IDLE
      vecs[8]  = mk(1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 5'd2,  1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd2,  1'b1, 1'b0);
      vecs[10] = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd1,  1'b1, 1'b0); // start in RUN
      vecs[11] = mk(1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1);
      vecs[12] = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0); // start in DONE
      vecs[13] = mk(1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0); // load beats start
      vecs[14] = mk(1'b1, 1'b1, 5'd3,  1'b0, 1'b0, 5'd3,  1'b0, 1'b0);
      vecs[15] = mk(1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd3,  1'b1, 1'b0);
      vecs[16] = mk(1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'd3,  1'b1, 1'b0); // gated abort
      vecs[17] = mk(1'b1, 1'b1, 5'd4,  1'b1, 1'b1, 5'd4,  1'b0, 1'b0);

      #12;
      check_now(0, 5'd0, 1'b0, 1'b0, "reset_state");
      check_now(1, 5'd0, 1'b0, 1'b0, "reset_state_ar");
      @(posedge clock);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(0, vecs[i].ce, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ab,
              vecs[i].e_it, vecs[i].e_busy, vecs[i].e_done, $sformatf("vec%0d", i));
      end

      // basic 30-edge countdown
      step(0, 1'b1, 1'b1, 5'b11110, 1'b0, 1'b0, 5'd30, 1'b0, 1'b0, "basic_load");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd30, 1'b1, 1'b0, "basic_start");
      for (int k = 1; k <= 30; k++) begin
         step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(30 - k), (k < 30), (k == 30),
              $sformatf("basic_edge%0d", k));
      end
      step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "basic_idle");

      // clock gating at iterator 12
      step(0, 1'b1, 1'b1, 5'd30, 1'b0, 1'b0, 5'd30, 1'b0, 1'b0, "gate_load");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd30, 1'b1, 1'b0, "gate_start");
      for (int k = 1; k <= 18; k++) begin
         step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(30 - k), 1'b1, 1'b0,
              $sformatf("gate_pre%0d", k));
      end
      for (int g = 0; g < 7; g++) begin
         step(0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, $sformatf("gate_hold%0d", g));
      end
      for (int k = 19; k <= 30; k++) begin
         step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(30 - k), (k < 30), (k == 30),
              $sformatf("gate_post%0d", k));
      end

      // load + start while running at 9
      step(0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, "prio_load9");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, "prio_start");
      step(0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, "prio_load4");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, "prio_restart");
      for (int k = 1; k <= 4; k++) begin
         step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(4 - k), (k < 4), (k == 4),
              $sformatf("prio_edge%0d", k));
      end

      // async reset mid-countdown at 20
      step(0, 1'b1, 1'b1, 5'd20, 1'b0, 1'b0, 5'd20, 1'b0, 1'b0, "rst_load");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b0, "rst_start");
      #2;
      reset = 1'b0;
      #1;
      check_now(0, 5'd0, 1'b0, 1'b0, "rst_immediate");
      for (int k = 0; k < 3; k++) begin
         step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, $sformatf("rst_held%0d", k));
      end
      reset = 1'b1;
      step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "rst_release");
      step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, "rst_zero_start");

      // auto-reload instance: 3,2,1,0 repeating until abort
      step(1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, "ar_load");
      step(1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, "ar_start");
      for (int k = 1; k <= 10; k++) begin
         step(1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(3 - (k % 4)), ((k % 4) != 3), ((k % 4) == 3),
              $sformatf("ar_edge%0d", k));
      end
      // k=10 leaves iterator 1 in RUN
      step(1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, "ar_abort");
      step(1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, "ar_idle");
      step(1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "ar_load0");
      step(1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, "ar_zero_start");
      step(1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "ar_zero_idle");

      // randomized load values through the plain counter
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 31);
         step(0, 1'b1, 1'b1, 5'(n), 1'b0, 1'b0, 5'(n), 1'b0, 1'b0, $sformatf("rnd%0d_load", r));
         step(0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'(n), 1'b1, 1'b0, $sformatf("rnd%0d_start", r));
         for (int k = 1; k <= n; k++) begin
            step(0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'(n - k), (k < n), (k == n),
                 $sformatf("rnd%0d_edge%0d", r, k));
         end
      end

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_queue: %0d entries, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
